// File: rtl/stopwatch_lap_ctl.sv
// Stopwatch control FSM with lap capture memory and review mode.
// Optional macro LAP_ON_PAUSE_EN: pausing from COUNTING also captures a lap.
module stopwatch_lap_ctl #(
  parameter  int CNT_W     = 16,
  parameter  int LAP_DEPTH = 8,
  localparam int IDX_W     = $clog2(LAP_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic             split,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             init_regs,
  output logic             count_enabled,
  output logic             review,
  output logic [IDX_W-1:0] lap_idx,
  output logic [CNT_W-1:0] lap_value,
  output logic [IDX_W:0]   lap_count,
  output logic             lap_full,
  output logic             lap_ovf
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_COUNTING = 4'b0010,
    ST_PAUSED   = 4'b0100,
    ST_REVIEW   = 4'b1000
  } state_t;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(LAP_DEPTH);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] lap_idx_q, lap_idx_d;
  logic [IDX_W:0]   lap_count_q, lap_count_d;
  logic             lap_ovf_q, lap_ovf_d;
  logic [CNT_W-1:0] lap_value_q, lap_value_d;
  logic [CNT_W-1:0] lap_mem_q [LAP_DEPTH];

  logic             capture;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic             full;

  assign full = (lap_count_q == DEPTH_L);

  always_comb begin
    state_d     = state_q;
    lap_idx_d   = lap_idx_q;
    lap_count_d = lap_count_q;
    lap_ovf_d   = lap_ovf_q;
    capture     = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = lap_count_q[IDX_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d     = ST_COUNTING;
          lap_count_d = '0;
          lap_ovf_d   = 1'b0;
        end else if (split && (lap_count_q != '0)) begin
          state_d   = ST_REVIEW;
          lap_idx_d = '0;
        end
      end
      ST_COUNTING: begin
        if (trig) begin
          state_d = ST_PAUSED;
`ifdef LAP_ON_PAUSE_EN
          capture = 1'b1;
`endif
        end else if (split) begin
          capture = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (trig) begin
          state_d = ST_COUNTING;
        end else if (split) begin
          state_d = ST_IDLE;
        end
      end
      ST_REVIEW: begin
        if (trig) begin
          state_d   = ST_IDLE;
          lap_idx_d = '0;
        end else if (split) begin
          if (({1'b0, lap_idx_q} + 1'b1) >= lap_count_q) begin
            lap_idx_d = '0;
          end else begin
            lap_idx_d = lap_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        lap_idx_d = '0;
      end
    endcase

    // Capture is shared by split and (optionally) pause; full drops and flags overflow.
    if (capture) begin
      if (full) begin
        lap_ovf_d = 1'b1;
      end else begin
        mem_we      = 1'b1;
        lap_count_d = lap_count_q + 1'b1;
      end
    end

    lap_value_d = (state_q == ST_REVIEW) ? lap_mem_q[lap_idx_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lap_idx_q   <= '0;
      lap_count_q <= '0;
      lap_ovf_q   <= 1'b0;
      lap_value_q <= '0;
    end else begin
      state_q     <= state_d;
      lap_idx_q   <= lap_idx_d;
      lap_count_q <= lap_count_d;
      lap_ovf_q   <= lap_ovf_d;
      lap_value_q <= lap_value_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      lap_mem_q[mem_waddr] <= cnt_in;
    end
  end

  assign init_regs     = (state_q == ST_IDLE) || (state_q == ST_REVIEW);
  assign count_enabled = (state_q == ST_COUNTING);
  assign review        = (state_q == ST_REVIEW);
  assign lap_idx       = lap_idx_q;
  assign lap_value     = lap_value_q;
  assign lap_count     = lap_count_q;
  assign lap_full      = full;
  assign lap_ovf       = lap_ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_ctl.sv
// Scoreboard bench for stopwatch_lap_ctl: stimulus queues expectations, a negedge monitor checks them.
module tb_stopwatch_lap_ctl;

  localparam int CNT_W     = 16;
  localparam int LAP_DEPTH = 8;
  localparam int IDX_W     = $clog2(LAP_DEPTH);
`ifdef LAP_ON_PAUSE_EN
  localparam int PC = 1;
`else
  localparam int PC = 0;
`endif

  localparam int SIG_INIT = 0, SIG_CEN = 1, SIG_REV = 2, SIG_IDX = 3;
  localparam int SIG_VAL  = 4, SIG_CNT = 5, SIG_FULL = 6, SIG_OVF = 7;

  logic             clk = 1'b0;
  logic             reset, trig, split;
  logic [CNT_W-1:0] cnt_in;
  logic             init_regs, count_enabled, review, lap_full, lap_ovf;
  logic [IDX_W-1:0] lap_idx;
  logic [CNT_W-1:0] lap_value;
  logic [IDX_W:0]   lap_count;

  stopwatch_lap_ctl #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk), .reset(reset), .trig(trig), .split(split), .cnt_in(cnt_in),
    .init_regs(init_regs), .count_enabled(count_enabled), .review(review),
    .lap_idx(lap_idx), .lap_value(lap_value), .lap_count(lap_count),
    .lap_full(lap_full), .lap_ovf(lap_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string name;
    int    sig;
    int    val;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int act(input int sig);
    case (sig)
      SIG_INIT: return int'(init_regs);
      SIG_CEN:  return int'(count_enabled);
      SIG_REV:  return int'(review);
      SIG_IDX:  return int'(lap_idx);
      SIG_VAL:  return int'(lap_value);
      SIG_CNT:  return int'(lap_count);
      SIG_FULL: return int'(lap_full);
      default:  return int'(lap_ovf);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   a;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      a = act(e.sig);
      n_tests++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end else if (a != e.val) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.val, cyc);
      end
    end
  end

  task automatic expect_sig(input string name, input int sig, input int val);
    exp_t e;
    e.cyc = cyc; e.name = name; e.sig = sig; e.val = val;
    sbq.push_back(e);
  endtask

  // st: 0 idle, 1 counting, 2 paused, 3 review
  task automatic expect_state(input string name, input int st);
    expect_sig({name, "_init"}, SIG_INIT, (st == 0 || st == 3) ? 1 : 0);
    expect_sig({name, "_cen"},  SIG_CEN,  (st == 1) ? 1 : 0);
    expect_sig({name, "_rev"},  SIG_REV,  (st == 3) ? 1 : 0);
  endtask

  task automatic drive(input logic r, input logic t, input logic s, input int c);
    reset = r; trig = t; split = s; cnt_in = CNT_W'(c);
    @(posedge clk);
    #1;
    reset = 1'b0; trig = 1'b0; split = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (queue %0d)", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin
    int laps[4];
    int n;
    laps[0] = 5; laps[1] = 9; laps[2] = 20; laps[3] = 77;
    n = 3 + PC;
    reset = 1'b1; trig = 1'b0; split = 1'b0; cnt_in = '0;

    // 1: reset
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    expect_state("rst", 0);
    expect_sig("rst_idx", SIG_IDX, 0);
    expect_sig("rst_val", SIG_VAL, 0);
    expect_sig("rst_cnt", SIG_CNT, 0);
    expect_sig("rst_full", SIG_FULL, 0);
    expect_sig("rst_ovf", SIG_OVF, 0);

    // 2: capture and review
    drive(0, 1, 0, 0);   expect_state("t2_run", 1); expect_sig("t2_cnt0", SIG_CNT, 0);
    drive(0, 0, 1, 5);   expect_sig("t2_cnt1", SIG_CNT, 1);
    drive(0, 0, 1, 9);   expect_sig("t2_cnt2", SIG_CNT, 2);
    drive(0, 0, 1, 20);  expect_sig("t2_cnt3", SIG_CNT, 3);
    drive(0, 1, 0, 77);  expect_state("t2_pause", 2); expect_sig("t2_cntp", SIG_CNT, n);
    drive(0, 0, 1, 0);   expect_state("t2_idle", 0); expect_sig("t2_keep", SIG_CNT, n);
    drive(0, 0, 1, 0);   expect_state("t2_rev", 3); expect_sig("t2_idx0", SIG_IDX, 0);
    expect_sig("t2_val_lat", SIG_VAL, 0);
    drive(0, 0, 0, 0);   expect_sig("t2_val0", SIG_VAL, 5);
    for (int i = 1; i <= n; i++) begin
      drive(0, 0, 1, 0);
      expect_sig("t2_idx", SIG_IDX, i % n);
      expect_sig("t2_val_old", SIG_VAL, laps[i-1]);
      drive(0, 0, 0, 0);
      expect_sig("t2_val", SIG_VAL, laps[i % n]);
    end
    drive(0, 1, 0, 0);   expect_state("t2_exit", 0); expect_sig("t2_exit_idx", SIG_IDX, 0);
    drive(0, 0, 0, 0);   expect_sig("t2_exit_val", SIG_VAL, 0);

    // 4: trig & split together, trig wins
    drive(0, 1, 0, 0);   expect_state("t4_run", 1); expect_sig("t4_clr", SIG_CNT, 0);
    drive(0, 0, 1, 11);  expect_sig("t4_cnt1", SIG_CNT, 1);
    drive(0, 1, 1, 33);  expect_state("t4_pause", 2);
    expect_sig("t4_cnt", SIG_CNT, 1 + PC);
    expect_sig("t4_ovf", SIG_OVF, 0);
    drive(0, 0, 1, 0);   expect_state("t4_idle", 0);

    // 3: fill and overflow
    drive(0, 1, 0, 0);   expect_state("t3_run", 1); expect_sig("t3_clr", SIG_CNT, 0);
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 1, 100 + i);
      expect_sig("t3_cnt", SIG_CNT, (i + 1 > 8) ? 8 : i + 1);
      expect_sig("t3_full", SIG_FULL, (i >= 7) ? 1 : 0);
      expect_sig("t3_ovf", SIG_OVF, (i >= 8) ? 1 : 0);
    end
    drive(0, 1, 0, 200); expect_state("t3_pause", 2);
    expect_sig("t3_cntp", SIG_CNT, 8); expect_sig("t3_ovfp", SIG_OVF, 1);
    drive(0, 0, 1, 0);   expect_state("t3_idle", 0);
    drive(0, 0, 1, 0);   expect_state("t3_rev", 3);
    drive(0, 0, 0, 0);   expect_sig("t3_val0", SIG_VAL, 100);
    for (int i = 1; i < 8; i++) begin
      drive(0, 0, 1, 0);
      expect_sig("t3_idx", SIG_IDX, i);
    end
    drive(0, 0, 0, 0);   expect_sig("t3_val7", SIG_VAL, 107);

    // 5: reset during review
    drive(0, 0, 1, 0);   expect_sig("t5_wrap", SIG_IDX, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);   expect_sig("t5_idx2", SIG_IDX, 2);
    drive(1, 0, 0, 0);   expect_state("t5_rst", 0);
    expect_sig("t5_cnt", SIG_CNT, 0); expect_sig("t5_idx", SIG_IDX, 0);
    expect_sig("t5_full", SIG_FULL, 0); expect_sig("t5_ovf", SIG_OVF, 0);
    expect_sig("t5_val", SIG_VAL, 0);
    drive(0, 0, 1, 0);   expect_state("t5_ign", 0); expect_sig("t5_ign_cnt", SIG_CNT, 0);
    drive(0, 0, 0, 0);   expect_sig("t5_ign_val", SIG_VAL, 0);

    // 6: pause capture
    drive(0, 1, 0, 0);   expect_state("t6_run", 1);
    drive(0, 0, 1, 7);   expect_sig("t6_cnt1", SIG_CNT, 1);
    drive(0, 1, 0, 42);  expect_state("t6_pause", 2); expect_sig("t6_cnt", SIG_CNT, 1 + PC);
    drive(0, 0, 1, 0);   expect_state("t6_idle", 0);
    drive(0, 0, 1, 0);   expect_state("t6_rev", 3);
    if (PC == 1) begin
      drive(0, 0, 1, 0); expect_sig("t6_idx1", SIG_IDX, 1);
    end
    drive(0, 0, 0, 0);   expect_sig("t6_last", SIG_VAL, (PC == 1) ? 42 : 7);

    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked (due cycle %0d)", e.name, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
